// File: rtl/wb_regfile_mt.sv
// Writeback result select plus banked per-thread register file for the barrel core.
// A post-reset sweep zeroes every bank before ready is raised and writes are accepted.
module wb_regfile_mt #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BITS_THREADS  = 3
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     reg_write_w,
  input  logic [1:0]               result_src_w,
  input  logic [DATA_WIDTH-1:0]    alu_result_w,
  input  logic [DATA_WIDTH-1:0]    read_data_w,
  input  logic [4:0]               rd_w,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_w,
  input  logic [BITS_THREADS-1:0]  tid_w,
  input  logic [BITS_THREADS-1:0]  tid_d,
  input  logic [4:0]               rs1_d,
  input  logic [4:0]               rs2_d,
  output logic [DATA_WIDTH-1:0]    rd1_d,
  output logic [DATA_WIDTH-1:0]    rd2_d,
  output logic [DATA_WIDTH-1:0]    result_w,
  output logic                     ready
);

  localparam int NUM_THREADS = 2 ** BITS_THREADS;
  localparam int ENTRIES     = NUM_THREADS * 32;

  typedef enum logic { ST_CLEAR = 1'b0, ST_RUN = 1'b1 } state_t;

  state_t                  state;
  logic [4:0]              sweep_idx;
  logic [DATA_WIDTH-1:0]   regs [ENTRIES];
  logic                    wr_en;

  // Code 2'b11 is reserved and aliases the ALU result.
  function automatic logic [DATA_WIDTH-1:0] select_result(
    input logic [1:0]               src,
    input logic [DATA_WIDTH-1:0]    alu,
    input logic [DATA_WIDTH-1:0]    mem,
    input logic [ADDRESS_WIDTH-1:0] link
  );
    case (src)
      2'b01:   return mem;
      2'b10:   return DATA_WIDTH'(link);
      default: return alu;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [4:0]              rs,
    input logic [BITS_THREADS-1:0] tid,
    input logic                    rdy,
    input logic                    we,
    input logic [4:0]              rd,
    input logic [BITS_THREADS-1:0] wtid,
    input logic [DATA_WIDTH-1:0]   wdata,
    input logic [DATA_WIDTH-1:0]   stored
  );
    if (rs == 5'd0 || !rdy)
      return '0;
    else if (we && rd == rs && wtid == tid)
      return wdata;
    else
      return stored;
  endfunction

  assign result_w = select_result(result_src_w, alu_result_w, read_data_w, pc_plus4_w);
  assign wr_en    = ready && reg_write_w && (rd_w != 5'd0);

  // Control: sweep FSM and ready flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_CLEAR;
      sweep_idx <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          sweep_idx <= sweep_idx + 5'd1;
          if (sweep_idx == 5'd31) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage: no direct reset, the sweep zeroes one index across all banks per cycle.
  always_ff @(posedge clk) begin
    if (!clr && state == ST_CLEAR) begin
      for (int t = 0; t < NUM_THREADS; t++)
        regs[{BITS_THREADS'(t), sweep_idx}] <= '0;
    end else if (wr_en) begin
      regs[{tid_w, rd_w}] <= result_w;
    end
  end

  assign rd1_d = read_port(rs1_d, tid_d, ready, reg_write_w, rd_w, tid_w, result_w,
                           regs[{tid_d, rs1_d}]);
  assign rd2_d = read_port(rs2_d, tid_d, ready, reg_write_w, rd_w, tid_w, result_w,
                           regs[{tid_d, rs2_d}]);

endmodule

// File: tb/tb_wb_regfile_mt.sv
// Scoreboard bench for wb_regfile_mt: stimulus pushes expected outputs from an
// abstract model, a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile_mt;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BT = 3;
  localparam int NT = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic          reg_write_w;
  logic [1:0]    result_src_w;
  logic [DW-1:0] alu_result_w;
  logic [DW-1:0] read_data_w;
  logic [4:0]    rd_w;
  logic [AW-1:0] pc_plus4_w;
  logic [BT-1:0] tid_w;
  logic [BT-1:0] tid_d;
  logic [4:0]    rs1_d;
  logic [4:0]    rs2_d;
  logic [DW-1:0] rd1_d;
  logic [DW-1:0] rd2_d;
  logic [DW-1:0] result_w;
  logic          ready;

  always #5 clk = ~clk;

  wb_regfile_mt #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BITS_THREADS(BT)) dut (
    .clk(clk), .clr(clr), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .alu_result_w(alu_result_w), .read_data_w(read_data_w), .rd_w(rd_w),
    .pc_plus4_w(pc_plus4_w), .tid_w(tid_w), .tid_d(tid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .result_w(result_w), .ready(ready)
  );

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] res;
    logic          rdy;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] mem [NT][32];
  bit            m_ready = 1'b0;
  int            m_cnt = 0;
  bit            started = 1'b0;

  function automatic logic [DW-1:0] m_result();
    if (result_src_w == 2'd1) return read_data_w;
    if (result_src_w == 2'd2) return pc_plus4_w;
    return alu_result_w;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [4:0] rs, input logic [DW-1:0] res);
    if (rs == 0 || !m_ready) return '0;
    if (reg_write_w && rd_w == rs && tid_w == tid_d) return res;
    return mem[tid_d][rs];
  endfunction

  task automatic cmp(input string nm, input int c, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("ready", e.cyc, {31'd0, ready}, {31'd0, e.rdy});
      cmp("result_w", e.cyc, result_w, e.res);
      cmp("rd1_d", e.cyc, rd1_d, e.rd1);
      cmp("rd2_d", e.cyc, rd2_d, e.rd2);
    end
  end

  // Applies current inputs for one cycle: push expectation, clock, update model.
  task automatic tick();
    exp_t e;
    if (started) begin
      e.res = m_result();
      e.rd1 = m_read(rs1_d, e.res);
      e.rd2 = m_read(rs2_d, e.res);
      e.rdy = m_ready;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    if (clr) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      started = 1'b1;
    end else if (started) begin
      if (m_ready && reg_write_w && rd_w != 0) mem[tid_w][rd_w] = m_result();
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == 32) begin
          m_ready = 1'b1;
          for (int t = 0; t < NT; t++)
            for (int r = 0; r < 32; r++) mem[t][r] = '0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; reg_write_w = 1'b0; result_src_w = 2'd0;
    alu_result_w = '0; read_data_w = '0; rd_w = '0; pc_plus4_w = '0;
    tid_w = '0; tid_d = '0; rs1_d = '0; rs2_d = '0;
  endtask

  task automatic wr(input logic [BT-1:0] t, input logic [4:0] r, input logic [1:0] src,
                    input logic [DW-1:0] v);
    reg_write_w = 1'b1; tid_w = t; rd_w = r; result_src_w = src;
    alu_result_w = v; read_data_w = v; pc_plus4_w = v;
  endtask

  task automatic randomize_inputs(input bit allow_clr);
    clr          = allow_clr && ($urandom_range(0, 199) == 0);
    reg_write_w  = ($urandom_range(0, 2) != 0);
    result_src_w = 2'($urandom_range(0, 3));
    alu_result_w = $urandom;
    read_data_w  = $urandom;
    pc_plus4_w   = $urandom;
    rd_w         = 5'($urandom_range(0, 7));
    tid_w        = BT'($urandom_range(0, 3));
    tid_d        = ($urandom_range(0, 1) != 0) ? tid_w : BT'($urandom_range(0, 3));
    rs1_d        = ($urandom_range(0, 3) == 0) ? rd_w : 5'($urandom_range(0, 7));
    rs2_d        = ($urandom_range(0, 3) == 0) ? rs1_d : 5'($urandom_range(0, 31));
  endtask

  initial begin
    int guard;
    idle();
    @(posedge clk); #1;

    // Reset and sweep: reads 0 and ready low until the 32nd edge.
    clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0;
    for (int i = 0; i < 34; i++) begin
      rs1_d = 5'($urandom_range(0, 31)); rs2_d = 5'($urandom_range(0, 31));
      tid_d = BT'($urandom_range(0, 7));
      tick();
    end

    // Write in thread 3, read back from thread 3 and 2.
    idle(); wr(3'd3, 5'd5, 2'd0, 32'hDEADBEEF); tid_d = 3'd3; rs1_d = 5'd5; tick();
    idle(); tid_d = 3'd3; rs1_d = 5'd5; rs2_d = 5'd5; tick();
    tid_d = 3'd2; tick();

    // Same-cycle bypass from load data, thread-gated.
    idle(); wr(3'd1, 5'd7, 2'd1, 32'h1234); tid_d = 3'd1; rs2_d = 5'd7; tick();
    tid_d = 3'd0; tick();

    // x0 writes dropped; link value writeback.
    idle(); wr(3'd0, 5'd0, 2'd0, 32'hFFFFFFFF);
    for (int t = 0; t < NT; t++) begin tid_d = BT'(t); rs1_d = 5'd0; tick(); end
    idle(); wr(3'd0, 5'd1, 2'd2, 32'h100); tid_d = 3'd0; rs1_d = 5'd1; tick();
    idle(); rs1_d = 5'd1; rs2_d = 5'd0; tick();

    // Write during sweep is dropped; the sweep clears earlier contents.
    idle(); wr(3'd0, 5'd9, 2'd0, 32'hAA); tick();
    idle(); clr = 1'b1; tick();
    clr = 1'b0; repeat (10) tick();
    wr(3'd0, 5'd9, 2'd0, 32'h55); tid_d = 3'd0; rs1_d = 5'd9; tick();
    idle();
    guard = 0;
    while (!m_ready && guard < 40) begin tick(); guard++; end
    for (int t = 0; t < NT; t++) begin tid_d = BT'(t); rs1_d = 5'd9; rs2_d = 5'd9; tick(); end

    // Restart mid-sweep: ready waits a full 32 edges after the second release.
    idle(); clr = 1'b1; tick();
    clr = 1'b0; repeat (20) tick();
    clr = 1'b1; tick();
    clr = 1'b0; repeat (33) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      randomize_inputs(1'b1);
      tick();
    end
    idle(); clr = 1'b1; tick();
    clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      randomize_inputs(1'b0);
      tick();
    end

    idle();
    @(posedge clk); @(posedge clk); #1;
    cmp("sb_drain", cyc, DW'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
